// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// The request struct widths are the default memory geometry.
package dmem_pkg;

    localparam int DM_ADDR_W_DEF = 9;
    localparam int DATA_W_DEF    = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [0:0] {S_CPU, S_DMA_BURST} arb_state_t;

    typedef struct packed {
        logic                     we;
        logic [DM_ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0]    wdata;
        logic [2:0]               funct3;
    } dmem_req_t;

endpackage

// File: rtl/dmem_rsp_reg.sv
// Registered load-return stage: captures memory read data at the end of the
// grant cycle and presents it with a one-cycle valid.
module dmem_rsp_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] rd,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata
);

    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    always_comb begin
        rvalid_d = load;
        rdata_d  = load ? rd : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for the data-memory port: CPU priority, anti-starvation
// forced DMA grant, and locked DMA bursts of bounded length.
module dmem_port_arbiter
    import dmem_pkg::*;
#(
    parameter int DM_ADDRESS = DM_ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = 4,
    parameter int BURST_MAX  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [DM_ADDRESS-1:0] cpu_addr,
    input  logic [DATA_W-1:0]     cpu_wdata,
    input  logic [2:0]            cpu_funct3,
    output logic                  cpu_gnt,
    output logic                  cpu_stall,
    output logic                  cpu_rvalid,
    output logic [DATA_W-1:0]     cpu_rdata,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [DM_ADDRESS-1:0] dma_addr,
    input  logic [DATA_W-1:0]     dma_wdata,
    input  logic [2:0]            dma_funct3,
    input  logic                  dma_lock,
    output logic                  dma_gnt,
    output logic                  dma_rvalid,
    output logic [DATA_W-1:0]     dma_rdata,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic [DM_ADDRESS-1:0] a,
    output logic [DATA_W-1:0]     wd,
    output logic [2:0]            Funct3,
    input  logic [DATA_W-1:0]     rd
);

    localparam int SCW = $clog2(STARVE_MAX + 1);
    localparam int BCW = $clog2(BURST_MAX + 1);

    arb_state_t     state_q, state_d;
    logic [SCW-1:0] starve_cnt_q, starve_cnt_d;
    logic [BCW-1:0] burst_cnt_q, burst_cnt_d;
    logic           burst_hold, force_dma;
    dmem_req_t      cpu_r, dma_r, sel_r;

    always_comb begin
        cpu_r = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata, funct3: cpu_funct3};
        dma_r = '{we: dma_we, addr: dma_addr, wdata: dma_wdata, funct3: dma_funct3};
    end

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        burst_cnt_d  = burst_cnt_q;
        cpu_gnt      = 1'b0;
        dma_gnt      = 1'b0;
        burst_hold   = (state_q == S_DMA_BURST) && dma_req && dma_lock;
        force_dma    = dma_req && (starve_cnt_q == SCW'(STARVE_MAX));

        // A burst that has ended falls back to CPU-priority arbitration in the
        // same cycle, so no port cycle is wasted on the handover.
        if (burst_hold)
            dma_gnt = 1'b1;
        else if (cpu_req && !force_dma)
            cpu_gnt = 1'b1;
        else if (dma_req)
            dma_gnt = 1'b1;

        if (burst_hold) begin
            if (burst_cnt_q == BCW'(BURST_MAX - 1)) begin
                state_d     = S_CPU;
                burst_cnt_d = '0;
            end else begin
                burst_cnt_d = burst_cnt_q + BCW'(1);
            end
        end else if (dma_gnt && dma_lock && (BURST_MAX > 1)) begin
            // The grant that opens the burst counts as its first beat.
            state_d     = S_DMA_BURST;
            burst_cnt_d = BCW'(1);
        end else begin
            state_d     = S_CPU;
            burst_cnt_d = '0;
        end

        if (dma_gnt || !dma_req)
            starve_cnt_d = '0;
        else if (cpu_gnt && (starve_cnt_q != SCW'(STARVE_MAX)))
            starve_cnt_d = starve_cnt_q + SCW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_CPU;
            starve_cnt_q <= '0;
            burst_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

    always_comb begin
        sel_r = '0;
        if (cpu_gnt)
            sel_r = cpu_r;
        else if (dma_gnt)
            sel_r = dma_r;
        MemRead  = (cpu_gnt || dma_gnt) && !sel_r.we;
        MemWrite = (cpu_gnt || dma_gnt) && sel_r.we;
        a        = sel_r.addr;
        wd       = sel_r.wdata;
        Funct3   = sel_r.funct3;
    end

    assign cpu_stall = cpu_req && !cpu_gnt;

    dmem_rsp_reg #(.DATA_W(DATA_W)) u_cpu_rsp (
        .clk    (clk),
        .reset  (reset),
        .load   (cpu_gnt && !cpu_we),
        .rd     (rd),
        .rvalid (cpu_rvalid),
        .rdata  (cpu_rdata)
    );

    dmem_rsp_reg #(.DATA_W(DATA_W)) u_dma_rsp (
        .clk    (clk),
        .reset  (reset),
        .load   (dma_gnt && !dma_we),
        .rd     (rd),
        .rvalid (dma_rvalid),
        .rdata  (dma_rdata)
    );

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a byte-addressed memory model and
// per-requester load-data scoreboards.
module tb_dmem_port_arbiter;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [8:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic [2:0]  cpu_funct3;
    logic        cpu_gnt, cpu_stall, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        dma_req, dma_we, dma_lock;
    logic [8:0]  dma_addr;
    logic [31:0] dma_wdata;
    logic [2:0]  dma_funct3;
    logic        dma_gnt, dma_rvalid;
    logic [31:0] dma_rdata;
    logic        MemRead, MemWrite;
    logic [8:0]  a;
    logic [31:0] wd;
    logic [2:0]  Funct3;
    logic [31:0] rd;

    logic        mem_init;
    logic [7:0]  mem [512];
    logic [31:0] cpu_q[$];
    logic [31:0] dma_q[$];
    int          tests = 0;
    int          fails = 0;
    int          k;
    logic        cpu_done;

    always #5 clk = ~clk;

    dmem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_funct3(cpu_funct3),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_funct3(dma_funct3), .dma_lock(dma_lock),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .MemRead(MemRead), .MemWrite(MemWrite), .a(a), .wd(wd),
        .Funct3(Funct3), .rd(rd)
    );

    function automatic logic [31:0] mem_rd(input logic [8:0] ad, input logic [2:0] f3);
        case (f3)
            F3_B:    return {{24{mem[ad][7]}}, mem[ad]};
            F3_BU:   return {24'h0, mem[ad]};
            F3_H:    return {{16{mem[ad+9'd1][7]}}, mem[ad+9'd1], mem[ad]};
            F3_HU:   return {16'h0, mem[ad+9'd1], mem[ad]};
            default: return {mem[{ad[8:2], 2'd3}], mem[{ad[8:2], 2'd2}],
                             mem[{ad[8:2], 2'd1}], mem[{ad[8:2], 2'd0}]};
        endcase
    endfunction

    always_comb rd = mem_rd(a, Funct3);

    // Memory commits writes at the end of the grant cycle.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 512; i++) mem[i] <= 8'h11;
            mem[16] <= 8'hEF; mem[17] <= 8'hBE; mem[18] <= 8'hAD; mem[19] <= 8'hDE;
        end else if (MemWrite) begin
            case (Funct3)
                F3_B: mem[a] <= wd[7:0];
                F3_H: begin mem[a] <= wd[7:0]; mem[a+9'd1] <= wd[15:8]; end
                default: begin
                    mem[{a[8:2], 2'd0}] <= wd[7:0];
                    mem[{a[8:2], 2'd1}] <= wd[15:8];
                    mem[{a[8:2], 2'd2}] <= wd[23:16];
                    mem[{a[8:2], 2'd3}] <= wd[31:24];
                end
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_funct3 = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0; dma_funct3 = '0;
        dma_lock = 0;
    endtask

    // Scoreboard: every rvalid must match the oldest expected load result.
    always @(negedge clk) begin
        if (cpu_rvalid) begin
            if (cpu_q.size() == 0) chk("cpu_rvalid_unexpected", 32'(cpu_rvalid), 32'd0);
            else                   chk("cpu_rdata", cpu_rdata, cpu_q.pop_front());
        end
        if (dma_rvalid) begin
            if (dma_q.size() == 0) chk("dma_rvalid_unexpected", 32'(dma_rvalid), 32'd0);
            else                   chk("dma_rdata", dma_rdata, dma_q.pop_front());
        end
    end

    initial begin
        idle_inputs();
        reset = 1; mem_init = 1;
        @(negedge clk);
        chk("rst_rvalid", {30'd0, cpu_rvalid, dma_rvalid}, 32'd0);
        chk("rst_rdata", cpu_rdata | dma_rdata, 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(S_CPU));
        tick();
        mem_init = 0; reset = 0;

        // CPU LW from 0x010
        cpu_req = 1; cpu_addr = 9'h010; cpu_funct3 = F3_W;
        cpu_q.push_back(32'hDEADBEEF);
        @(negedge clk);
        chk("lw_cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("lw_dma_gnt", 32'(dma_gnt), 32'd0);
        chk("lw_rd_wr", {30'd0, MemRead, MemWrite}, 32'd2);
        chk("lw_addr", 32'(a), 32'h010);
        tick(); idle_inputs();
        @(negedge clk);
        chk("lw_rvalid", 32'(cpu_rvalid), 32'd1);

        // SB 0xA5 to 0x003, then LBU and LW from the same word
        tick();
        cpu_req = 1; cpu_we = 1; cpu_addr = 9'h003; cpu_wdata = 32'hFFFF_FFA5; cpu_funct3 = F3_B;
        @(negedge clk);
        chk("sb_port", {26'd0, cpu_gnt, MemWrite, MemRead, Funct3}, {26'd0, 3'b110, F3_B});
        chk("sb_wd", wd, 32'hFFFF_FFA5);
        tick();
        cpu_we = 0; cpu_funct3 = F3_BU; cpu_q.push_back(32'h0000_00A5);
        @(negedge clk);
        chk("lbu_gnt", 32'(cpu_gnt), 32'd1);
        tick();
        cpu_addr = 9'h000; cpu_funct3 = F3_W; cpu_q.push_back(32'hA511_1111);
        @(negedge clk);
        tick(); idle_inputs();
        @(negedge clk);

        // Locked DMA burst of 12 SW with one CPU store arriving mid-burst
        k = 0; cpu_done = 0;
        for (int c = 0; c < 30 && k < 12; c++) begin
            tick();
            dma_req = 1; dma_lock = 1; dma_we = 1; dma_funct3 = F3_W;
            dma_addr = 9'(4 * k); dma_wdata = 32'h1000_0000 + 32'(k);
            cpu_req = (c >= 1) && !cpu_done; cpu_we = 1; cpu_addr = 9'h100;
            cpu_funct3 = F3_W; cpu_wdata = 32'(c);
            @(negedge clk);
            chk($sformatf("burst_dma_gnt_c%0d", c), 32'(dma_gnt), 32'(c != 8));
            chk($sformatf("burst_cpu_gnt_c%0d", c), 32'(cpu_gnt), 32'(c == 8));
            if (dma_gnt) chk($sformatf("burst_addr_k%0d", k), 32'(a), 32'(4 * k));
            if (cpu_gnt) cpu_done = 1;
            if (dma_gnt) k++;
        end
        chk("burst_count", 32'(k), 32'd12);
        tick(); idle_inputs();
        @(negedge clk);

        // Both requesting continuously: CPU x4 then one forced DMA
        for (int c = 0; c < 15; c++) begin
            tick();
            cpu_req = 1; cpu_we = 1; cpu_addr = 9'h1F4; cpu_funct3 = F3_W; cpu_wdata = 32'(c);
            dma_req = 1; dma_we = 1; dma_addr = 9'h1F0; dma_funct3 = F3_W; dma_lock = 0;
            @(negedge clk);
            chk($sformatf("starve_gnt_c%0d", c), {30'd0, cpu_gnt, dma_gnt},
                (c % 5 == 4) ? 32'd1 : 32'd2);
            chk($sformatf("starve_stall_c%0d", c), 32'(cpu_stall), 32'(c % 5 == 4));
        end
        tick(); idle_inputs();
        @(negedge clk);

        // Reset one cycle after a DMA load grant inside a burst
        tick();
        dma_req = 1; dma_lock = 1; dma_we = 0; dma_funct3 = F3_W; dma_addr = 9'h010;
        dma_q.push_back(32'h1000_0004);
        @(negedge clk);
        chk("mb_gnt0", 32'(dma_gnt), 32'd1);
        tick();
        dma_addr = 9'h014; dma_q.push_back(32'h1000_0005);
        @(negedge clk);
        chk("mb_in_burst", 32'(dut.state_q), 32'(S_DMA_BURST));
        tick();
        dma_addr = 9'h018;
        @(negedge clk);
        chk("mb_gnt2", 32'(dma_gnt), 32'd1);
        tick();
        reset = 1; idle_inputs();
        @(negedge clk);
        chk("mb_rst_rvalid", 32'(dma_rvalid), 32'd0);
        chk("mb_rst_state", 32'(dut.state_q), 32'(S_CPU));
        chk("mb_rst_cnts", 32'(dut.starve_cnt_q) | 32'(dut.burst_cnt_q), 32'd0);
        tick();
        reset = 0;

        // Idle: no port activity, no grants, no responses
        for (int c = 0; c < 20; c++) begin
            tick();
            @(negedge clk);
            chk($sformatf("idle_c%0d", c),
                {19'd0, MemRead, MemWrite, a, cpu_gnt, dma_gnt}, 32'd0);
        end
        chk("sb_empty", 32'(cpu_q.size() + dma_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
